// File: rtl/seq_detect_sched_pkg.sv
// Shared types and constants for the seq_detect_sched round-robin detector scheduler.
package seq_detect_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    RESULT
  } sched_state_e;

  localparam int DET_LAT = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld
);

  int idx;

  // Scan from the farthest offset down so the closest request to ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Shares one serial "1011" detector lane among N requesters, one word per job.
// Optional SEQ_DETECT_SCHED_STATS_EN adds a saturating total_match_o counter.
module seq_detect_sched
  import seq_detect_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N-1:0]                 req_valid_i,
  input  logic [N*WIDTH-1:0]           req_data_i,
  output logic [N-1:0]                 req_ready_o,
  output logic                         det_rst_o,
  output logic                         det_next_o,
  input  logic                         det_out_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [$clog2(N)-1:0]         res_id_o,
  output logic [$clog2(WIDTH+1)-1:0]   res_count_o,
  output logic                         busy_o
`ifdef SEQ_DETECT_SCHED_STATS_EN
  ,
  output logic [15:0]                  total_match_o
`endif
);

  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int BW  = $clog2(WIDTH);

  sched_state_e     state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [CW-1:0]    count_q;
  logic [BW-1:0]    step_q;
  logic [WIDTH-1:0] sh_q;

  logic [N-1:0]     gnt;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_vld;
  logic             accept;
  logic [WIDTH-1:0] sel_word;
  logic             shift_last;
  logic             drain_last;

  rr_arbiter #(.N(N)) u_arb (
    .req     (req_valid_i),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  assign accept     = (state_q == IDLE) && gnt_vld;
  assign shift_last = (step_q == BW'(WIDTH - 1));
  assign drain_last = (step_q == BW'(DET_LAT - 1));

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) sel_word = req_data_i[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    det_next_o  = 1'b0;
    res_valid_o = 1'b0;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = rst_ni ? gnt : '0;
        if (gnt_vld) state_d = CLEAR;
      end
      CLEAR: state_d = SHIFT;
      SHIFT: begin
        det_next_o = sh_q[WIDTH-1];
        if (shift_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_last) state_d = RESULT;
      end
      RESULT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Detector reset follows rst_ni asynchronously so an aborted job leaves it cleared.
  assign det_rst_o   = !rst_ni || (state_q == CLEAR);
  assign busy_o      = (state_q != IDLE);
  assign res_id_o    = id_q;
  assign res_count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      count_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            id_q    <= gnt_id;
            count_q <= '0;
            step_q  <= '0;
            ptr_q   <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
          end
        end
        CLEAR: step_q <= '0;
        SHIFT: begin
          count_q <= count_q + CW'(det_out_i);
          step_q  <= shift_last ? '0 : step_q + 1'b1;
        end
        DRAIN: begin
          count_q <= count_q + CW'(det_out_i);
          step_q  <= step_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Word shift register carries data only, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      sh_q <= sel_word;
    end else if (state_q == SHIFT) begin
      sh_q <= {sh_q[WIDTH-2:0], 1'b0};
    end
  end

`ifdef SEQ_DETECT_SCHED_STATS_EN
  logic [15:0] total_q;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      total_q <= '0;
    end else if ((state_q == RESULT) && res_ready_i) begin
      total_q <= sat_add16(total_q, count_q);
    end
  end

  assign total_match_o = total_q;
`endif

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Round-robin scheduler that shares a single serial "1011" Moore sequence-detector lane among N requesters. Each requester hands over a WIDTH-bit word. The block:
- resets the detector,
- shifts the word in MSB-first on the detector's `next_i`,
- drains the detector's two-cycle output latency,
- returns the match count tagged with the requester id.

It sits between the requesting datapath blocks and one instance of the detector.

## Interface
- `N`, 4: number of requesters (≥2)
- `WIDTH`, 8: bits per job word (≥4)
- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous reset, active-low
- `req_valid_i` in N: requester i has a word
- `req_data_i` in N*WIDTH: word of requester i at bits [i*WIDTH +: WIDTH]
- `req_ready_o` out N: one-hot accept, only in IDLE
- `det_rst_o` out 1: synchronous active-high reset to the detector
- `det_next_o` out 1: serial bit to the detector
- `det_out_i` in 1: detector match output
- `res_valid_o` out 1: result available
- `res_ready_i` in 1: result consumer ready
- `res_id_o` out $clog2(N): requester id of the result
- `res_count_o` out $clog2(WIDTH+1): matches found in the word
- `busy_o` out 1: state ≠ IDLE

## Operation
- Reset values:
  - state IDLE, round-robin pointer 0.
  - `req_ready_o`=0, `det_next_o`=0, `res_valid_o`=0, `res_id_o`=0, `res_count_o`=0, `busy_o`=0.
  - `det_rst_o`=1 while `rst_ni` low, so the detector is held in S0/out 0.
- IDLE: the grant goes to the first valid requester at or after the pointer, wrapping modulo N.
  - `req_ready_o[g]`=1 combinationally.
  - On the valid&ready edge: capture the word into a shift register, capture id g, clear the count, set pointer=(g+1) mod N, go to CLEAR.
  - No valid requests: stay in IDLE, outputs 0.
- CLEAR (1 cycle): `det_rst_o`=1, `det_next_o`=0, then go to SHIFT.
- SHIFT (WIDTH cycles): `det_next_o`=shift-register MSB; shift left each cycle; a bit counter runs 0..WIDTH-1; at WIDTH-1 go to DRAIN.
- DRAIN (DET_LAT=2 cycles): `det_next_o`=0. Zero padding cannot complete a new match.
- Counting: in SHIFT and DRAIN, `count += det_out_i`. The counter never exceeds WIDTH, so no saturation logic is needed.
- RESULT: `res_valid_o`=1 with `res_id_o`/`res_count_o` stable until `res_ready_i`. On the handshake edge, return to IDLE.
- Requests are not sampled in CLEAR, SHIFT, DRAIN or RESULT. `req_ready_o` stays all-zero there.
- A requester dropping valid before its grant is legal; it simply loses its turn.

## Timing
- Detector model: a bit presented in cycle t that completes "1011" gives `det_out_i`=1 in cycle t+2.
- Accept edge to first `res_valid_o` cycle: WIDTH+DET_LAT+1 cycles (11 at default).
- Minimum job period at `res_ready_i`=1: WIDTH+DET_LAT+3 cycles.
- Back-to-back requests:
  - The granted requester gets its next turn only after all other valid requesters have been served once.
  - A single active requester is served every job period.
- Reset asserted mid-job: the job is lost with no result, all outputs take reset values immediately (asynchronous), and the detector is held in reset.

## Configuration
- `SEQ_DETECT_SCHED_STATS_EN` defined:
  - Adds output `total_match_o` [15:0], the sum of `res_count_o` over all completed result handshakes.
  - Saturates at 16'hFFFF and resets to 0.
- `SEQ_DETECT_SCHED_STATS_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `seq_detect_sched_pkg` holds:
  - state enum `sched_state_e` (IDLE, CLEAR, SHIFT, DRAIN, RESULT),
  - localparam `DET_LAT` = 2.
- Sub-module `rr_arbiter` (N requests, pointer input, one-hot grant plus encoded id, purely combinational). The pointer register stays in the top module.

## Test plan
- Requester 0 sends 8'b1011_0110, `res_ready_i`=1 → `res_id_o`=0, `res_count_o`=2, `res_valid_o` high 11 cycles after accept.
- Requester 2 sends 8'b1011_1011 (second match completes on the last bit) → `res_count_o`=2; checks that the DRAIN window counts the late match.
- Requester 1 sends 8'hFF, then 8'h00 → `res_count_o`=0 both times; `det_rst_o` pulses once per job.
- All four requesters hold valid continuously → grant order 0,1,2,3,0,…; each `res_id_o` matches the order.
- Hold `res_ready_i`=0 for 5 cycles in RESULT → outputs stable, `req_ready_o`=0, accept occurs only after the handshake.
- Assert `rst_ni` low in the middle of SHIFT → immediate reset values, `det_rst_o`=1; the next job starts from pointer 0 and gives a correct count.
